// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: phase count default, phase width and sequencer states.
// No logic; imported by the sequencer and the control decoder.
package cpu_pkg;

    localparam int NUM_PHASES_DEF = 5;
    localparam int PHASE_W        = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } seq_state_t;

endpackage

// File: rtl/exec_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous panel button.
// Pulse appears two edges after the button is first sampled high; one cycle per press.
module exec_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       exec_prev_q;
    logic [1:0] prime_q;

    // sync2 holds reset zeros for two edges after rst; exec_prev stays high until
    // sync2 carries a real sample, so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            exec_prev_q <= 1'b1;
            prime_q     <= 2'b00;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            prime_q     <= {prime_q[0], 1'b1};
            exec_prev_q <= prime_q[1] ? sync2_q : 1'b1;
        end
    end

    assign pulse_o = sync2_q & ~exec_prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Steps instruction phases on front-panel exec presses (free run or single step), halts at boundaries.
// Start is three edges after exec is sampled high; stop_flag/stop requests act only in the last phase.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exec,
    input  logic                  step_mode,
    input  logic                  stop_flag,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_oh,
    output logic                  running,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      retired
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(NUM_PHASES - 1);

    logic               exec_pulse;
    seq_state_t         state_q;
    logic [PHASE_W-1:0] phase_q;
    logic               running_q;
    logic               stop_req_q;
    logic [CNT_W-1:0]   retired_q;
    logic               last_phase;

    exec_edge_sync u_exec_sync (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (exec),
        .pulse_o (exec_pulse)
    );

    assign last_phase = (phase_q == LAST);
    assign instr_done = running_q & last_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            running_q  <= 1'b0;
            stop_req_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            if (instr_done)
                retired_q <= retired_q + CNT_W'(1);

            case (state_q)
                IDLE: begin
                    phase_q <= '0;
                    if (exec_pulse) begin
                        state_q   <= step_mode ? STEP : RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_phase) begin
                        phase_q <= '0;
                        // A pulse landing exactly in the last phase stops now rather than lingering.
                        if (stop_flag | stop_req_q | exec_pulse) begin
                            state_q    <= IDLE;
                            running_q  <= 1'b0;
                            stop_req_q <= 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                        if (exec_pulse)
                            stop_req_q <= 1'b1;
                    end
                end
                STEP: begin
                    if (last_phase) begin
                        phase_q   <= '0;
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    phase_q    <= '0;
                    running_q  <= 1'b0;
                    stop_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        phase_oh = '0;
        for (int i = 0; i < NUM_PHASES; i++)
            phase_oh[i] = running_q && (phase_q == PHASE_W'(i));
    end

    assign phase   = phase_q;
    assign running = running_q;
    assign retired = retired_q;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Drives the `phase` input of the instruction control decoder and sequences instruction execution.
- Converts the asynchronous front-panel `exec` button into start/stop events, supports single-step mode, and steps phases 0..NUM_PHASES-1 once per instruction.
- Halts cleanly at an instruction boundary on HLT (`stop_flag`) or a user stop request.
- Counts retired instructions; sits between the board I/O and the control decoder.

Parameters:
- NUM_PHASES, 5, phases per instruction (2..8); phase values are 0..NUM_PHASES-1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- exec  in  1  raw front-panel button level, asynchronous to clk
- step_mode  in  1  1 = each exec press runs exactly one instruction
- stop_flag  in  1  from control decoder: current instruction is HLT; sampled only in the last phase
- phase  out  3  current phase number, to control decoder
- phase_oh  out  NUM_PHASES  one-hot phase; all zero when not running
- running  out  1  1 while executing
- instr_done  out  1  1-cycle strobe in the last phase of each executed instruction
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset values:
  - phase = 0, phase_oh = 0, running = 0, instr_done = 0, retired = 0
  - state = IDLE, stop_req = 0
  - sync1 = sync2 = 0; exec_prev = 1, so a button held through reset does not trigger a start.
- Exec synchroniser:
  - exec passes through sync1 -> sync2; exec_prev <= sync2 each cycle.
  - exec_pulse = sync2 & ~exec_prev (combinational from registers).
  - exec_pulse goes high in the cycle after the second rising clk edge that samples exec = 1, and stays high exactly 1 cycle per press.
- State IDLE: running = 0, phase = 0, phase_oh = 0.
  - exec_pulse & ~step_mode -> RUN.
  - exec_pulse & step_mode -> STEP.
  - In both cases phase = 0 and running = 1 in the next cycle.
- State RUN: phase increments by 1 each cycle and wraps from NUM_PHASES-1 to 0.
  - exec_pulse sets stop_req; stop_req is sticky until the next instruction boundary.
  - At last phase (LAST = NUM_PHASES-1):
    - if stop_flag | stop_req | exec_pulse: go to IDLE and clear stop_req;
    - otherwise continue with phase = 0.
- State STEP: phases advance as in RUN.
  - At LAST, always go to IDLE.
  - exec_pulse during STEP is ignored (dropped, not queued).
- instr_done = running & (phase == LAST); it is asserted in both RUN and STEP.
- retired increments on every cycle with instr_done = 1 and wraps from all-ones to 0. It is not cleared by stop; only rst clears it.
- phase_oh[i] = running & (phase == i).
- Simultaneous events:
  - stop_flag and exec_pulse both at LAST: go to IDLE; the pulse is consumed and does not restart.
  - step_mode changing while running takes effect only at the next start from IDLE.
- Reset mid-instruction: all state returns to reset values at the next edge, and the partial instruction is not counted.
- stop_flag outside the last phase is ignored.
- Latency from IDLE with exec rising before edge k:
  - exec_pulse high in cycle k+2;
  - running = 1 with phase 0 in cycle k+3.

Decomposition:
- Shared package cpu_pkg holds:
  - the NUM_PHASES default;
  - the state enum {IDLE, RUN, STEP} encoded 2'b00/01/10;
  - the PHASE_W = 3 constant, shared with the control decoder.
- One sub-module, exec_edge_sync: 2-flop synchroniser plus rising-edge detector, with exec_prev reset to 1. It is reusable for other panel buttons.

Test Plan:
1. Reset with exec held at 1, release rst, keep exec at 1 for 20 cycles -> running stays 0 and retired = 0.
2. step_mode = 0, one exec press, stop_flag = 0 -> phase sequence 0,1,2,3,4,0,1,...; instr_done every 5th cycle; retired = 4 after 20 running cycles. A second press during phase 2 -> running drops after the phase-4 cycle and retired = 5.
3. RUN with stop_flag = 1 driven only in phase 4 of the 3rd instruction -> IDLE after that cycle; retired = 3; phase = 0; phase_oh = 0.
4. stop_flag = 1 during phases 0..3 only -> no effect, continues running.
5. step_mode = 1, three presses spaced 10 cycles apart -> exactly 3 instructions and retired = 3. A press during an active STEP -> ignored, retired unchanged.
6. Force retired to 16'hFFFF (start from CNT_W-bit preload via long run or a CNT_W = 4 build at 4'hF), complete one instruction -> retired = 0. Assert rst in phase 2 -> all outputs at reset values at the next edge.
